// File: rtl/rat_int_pkg.sv
// rat_int_pkg: shared state encoding and the fixed interrupt vector for the interrupt shadow controller
package rat_int_pkg;
  typedef enum logic [1:0] {IDLE, TAKE, IN_ISR, RESTORE} state_t;
  localparam logic [9:0] INT_VECTOR = 10'h3FF;
endpackage

// File: rtl/int_edge_sync.sv
// int_edge_sync: optional 2-flop synchronizer (INT_SYNC_EN) followed by a rising-edge detector
// Ports: i_clk, i_rst_n (async active-low), i_in (raw level), o_pulse (1-cycle pulse per 0->1 edge)
module int_edge_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_in,
  output logic o_pulse
);
  logic w_in;
  logic r_prev;
`ifdef INT_SYNC_EN
  logic r_s1, r_s2;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_in;
      r_s2 <= r_s1;
    end
  assign w_in = r_s2;
`else
  assign w_in = i_in;
`endif
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_prev <= 1'b0;
    else          r_prev <= w_in;
  assign o_pulse = w_in & ~r_prev;
endmodule

// File: rtl/int_shadow_ctrl.sv
// int_shadow_ctrl: single-level interrupt controller that saves C/Z on entry and restores them on RETIE
// Ports: i_clk, i_rst_n (async active-low), i_intr, i_c_flag, i_z_flag, i_i_set, i_i_clr, i_instr_done, i_retie;
//        o_int_taken, o_shad_c, o_shad_z, o_flg_ld_sel, o_flg_restore, o_i_flag, o_int_vector
// Build option: INT_SYNC_EN adds a 2-flop synchronizer on i_intr
module int_shadow_ctrl
  import rat_int_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_intr,
  input  logic       i_c_flag,
  input  logic       i_z_flag,
  input  logic       i_i_set,
  input  logic       i_i_clr,
  input  logic       i_instr_done,
  input  logic       i_retie,
  output logic       o_int_taken,
  output logic       o_shad_c,
  output logic       o_shad_z,
  output logic       o_flg_ld_sel,
  output logic       o_flg_restore,
  output logic       o_i_flag,
  output logic [9:0] o_int_vector
);
  state_t r_state, w_next;
  logic   r_pend, r_i_flag, r_shad_c, r_shad_z;
  logic   w_edge, w_go;
  int_edge_sync u_edge (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_in    (i_intr),
    .o_pulse (w_edge)
  );
  assign w_go = (r_state == IDLE) & r_pend & r_i_flag & i_instr_done;
  always_comb begin
    w_next        = r_state;
    o_int_taken   = 1'b0;
    o_flg_ld_sel  = 1'b0;
    o_flg_restore = 1'b0;
    case (r_state)
      IDLE:    w_next = w_go ? TAKE : IDLE;
      TAKE:    begin
        w_next      = IN_ISR;
        o_int_taken = 1'b1;
      end
      IN_ISR:  w_next = i_retie ? RESTORE : IN_ISR;
      RESTORE: begin
        w_next        = IDLE;
        o_flg_ld_sel  = 1'b1;
        o_flg_restore = 1'b1;
      end
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next;
  // A fresh edge in the same cycle as the take is kept so it is serviced after return
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_pend   <= 1'b0;
      r_i_flag <= 1'b0;
      r_shad_c <= 1'b0;
      r_shad_z <= 1'b0;
    end else begin
      r_pend <= w_edge | (r_pend & ~w_go);
      if (r_state == TAKE) begin
        r_shad_c <= i_c_flag;
        r_shad_z <= i_z_flag;
        r_i_flag <= 1'b0;
      end else if (r_state == RESTORE) begin
        r_i_flag <= 1'b1;
      end else if (r_state == IDLE) begin
        r_i_flag <= i_i_clr ? 1'b0 : (i_i_set ? 1'b1 : r_i_flag);
      end
    end
  assign o_shad_c     = r_shad_c;
  assign o_shad_z     = r_shad_z;
  assign o_i_flag     = r_i_flag;
  assign o_int_vector = INT_VECTOR;
endmodule

// File: tb/tb_int_shadow_ctrl.sv
// tb_int_shadow_ctrl: directed self-checking bench for int_shadow_ctrl
module tb_int_shadow_ctrl;
`ifdef INT_SYNC_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif
  logic       i_clk = 1'b0;
  logic       i_rst_n, i_intr, i_c_flag, i_z_flag, i_i_set, i_i_clr, i_instr_done, i_retie;
  logic       o_int_taken, o_shad_c, o_shad_z, o_flg_ld_sel, o_flg_restore, o_i_flag;
  logic [9:0] o_int_vector;
  int n_checks = 0;
  int n_err = 0;
  int_shadow_ctrl dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_intr       (i_intr),
    .i_c_flag     (i_c_flag),
    .i_z_flag     (i_z_flag),
    .i_i_set      (i_i_set),
    .i_i_clr      (i_i_clr),
    .i_instr_done (i_instr_done),
    .i_retie      (i_retie),
    .o_int_taken  (o_int_taken),
    .o_shad_c     (o_shad_c),
    .o_shad_z     (o_shad_z),
    .o_flg_ld_sel (o_flg_ld_sel),
    .o_flg_restore(o_flg_restore),
    .o_i_flag     (o_i_flag),
    .o_int_vector (o_int_vector)
  );
  always #5 i_clk = ~i_clk;
  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(negedge i_clk);
  endtask
  task automatic chk_quiet(input string tag);
    chk({tag, "_taken"}, {9'd0, o_int_taken}, 10'd0);
    chk({tag, "_ldsel"}, {9'd0, o_flg_ld_sel}, 10'd0);
    chk({tag, "_rest"}, {9'd0, o_flg_restore}, 10'd0);
  endtask
  initial begin
    i_rst_n = 1'b0; i_intr = 1'b0; i_c_flag = 1'b0; i_z_flag = 1'b0;
    i_i_set = 1'b0; i_i_clr = 1'b0; i_instr_done = 1'b0; i_retie = 1'b0;
    step(); step();
    chk_quiet("rst");
    chk("rst_shc", {9'd0, o_shad_c}, 10'd0);
    chk("rst_shz", {9'd0, o_shad_z}, 10'd0);
    chk("rst_if", {9'd0, o_i_flag}, 10'd0);
    chk("vector", o_int_vector, 10'h3FF);
    i_rst_n = 1'b1;
    step();
    // basic entry: flags saved, I cleared, one-cycle take
    i_i_set = 1'b1; step(); i_i_set = 1'b0;
    chk("sei", {9'd0, o_i_flag}, 10'd1);
    i_c_flag = 1'b1; i_z_flag = 1'b0; i_intr = 1'b1;
    repeat (1 + SL) step();
    chk("pend_no_done", {9'd0, o_int_taken}, 10'd0);
    i_instr_done = 1'b1; step(); i_instr_done = 1'b0;
    chk("take1", {9'd0, o_int_taken}, 10'd1);
    step();
    chk("take1_end", {9'd0, o_int_taken}, 10'd0);
    chk("shc1", {9'd0, o_shad_c}, 10'd1);
    chk("shz1", {9'd0, o_shad_z}, 10'd0);
    chk("if_isr", {9'd0, o_i_flag}, 10'd0);
    // flags change in ISR, shadow must hold; RETIE restores
    i_c_flag = 1'b0; i_z_flag = 1'b1; step();
    chk("shc_hold", {9'd0, o_shad_c}, 10'd1);
    i_retie = 1'b1; step(); i_retie = 1'b0;
    chk("rest_ldsel", {9'd0, o_flg_ld_sel}, 10'd1);
    chk("rest_str", {9'd0, o_flg_restore}, 10'd1);
    chk("rest_shc", {9'd0, o_shad_c}, 10'd1);
    chk("rest_shz", {9'd0, o_shad_z}, 10'd0);
    chk("rest_if", {9'd0, o_i_flag}, 10'd0);
    step();
    chk_quiet("post_rest");
    chk("post_rest_if", {9'd0, o_i_flag}, 10'd1);
    i_intr = 1'b0;
    // clear beats set; RETIE in IDLE ignored
    i_i_set = 1'b1; i_i_clr = 1'b1; step(); i_i_set = 1'b0; i_i_clr = 1'b0;
    chk("clr_wins", {9'd0, o_i_flag}, 10'd0);
    i_retie = 1'b1; step(); i_retie = 1'b0;
    chk_quiet("retie_idle");
    step();
    chk_quiet("retie_idle2");
    // masked interrupt stays pending through several instructions
    i_intr = 1'b1; repeat (1 + SL) step(); i_intr = 1'b0;
    for (int k = 0; k < 5; k++) begin
      i_instr_done = 1'b1; step(); i_instr_done = 1'b0;
      chk("masked", {9'd0, o_int_taken}, 10'd0);
      step();
    end
    i_i_set = 1'b1; step(); i_i_set = 1'b0;
    i_instr_done = 1'b1; step(); i_instr_done = 1'b0;
    chk("unmask_take", {9'd0, o_int_taken}, 10'd1);
    step();
    chk("unmask_isr", {9'd0, o_int_taken}, 10'd0);
    chk("shc2", {9'd0, o_shad_c}, 10'd0);
    chk("shz2", {9'd0, o_shad_z}, 10'd1);
    // two edges inside the ISR merge into one later service
    i_intr = 1'b1; step(); i_intr = 1'b0; step();
    i_intr = 1'b1; step(); i_intr = 1'b0;
    repeat (SL + 1) step();
    chk("no_nest", {9'd0, o_int_taken}, 10'd0);
    i_retie = 1'b1; step(); i_retie = 1'b0;
    chk("rest2", {9'd0, o_flg_restore}, 10'd1);
    step();
    chk("if_back", {9'd0, o_i_flag}, 10'd1);
    i_instr_done = 1'b1; step(); i_instr_done = 1'b0;
    chk("second_take", {9'd0, o_int_taken}, 10'd1);
    step();
    chk("second_take_end", {9'd0, o_int_taken}, 10'd0);
    i_retie = 1'b1; step(); i_retie = 1'b0;
    step();
    i_instr_done = 1'b1; step(); i_instr_done = 1'b0;
    chk("merged", {9'd0, o_int_taken}, 10'd0);
    // reset in the middle of an ISR with a pending edge
    i_c_flag = 1'b1; i_z_flag = 1'b1; i_intr = 1'b1;
    repeat (1 + SL) step();
    i_instr_done = 1'b1; step(); i_instr_done = 1'b0;
    chk("take3", {9'd0, o_int_taken}, 10'd1);
    step();
    chk("shc3", {9'd0, o_shad_c}, 10'd1);
    chk("shz3", {9'd0, o_shad_z}, 10'd1);
    i_intr = 1'b0; step();
    i_intr = 1'b1; repeat (1 + SL) step();
    i_retie = 1'b1; step(); i_retie = 1'b0;
    chk("rest3", {9'd0, o_flg_restore}, 10'd1);
    #2 i_rst_n = 1'b0;
    #1;
    chk_quiet("async_rst");
    chk("async_shc", {9'd0, o_shad_c}, 10'd0);
    chk("async_shz", {9'd0, o_shad_z}, 10'd0);
    chk("async_if", {9'd0, o_i_flag}, 10'd0);
    i_intr = 1'b0;
    step(); i_rst_n = 1'b1;
    i_i_set = 1'b1; step(); i_i_set = 1'b0;
    i_instr_done = 1'b1; step();
    chk("pend_lost", {9'd0, o_int_taken}, 10'd0);
    // latency from INTR rise to INT_TAKEN with INSTR_DONE held high
    i_intr = 1'b1;
    for (int k = 1; k <= 2 + SL; k++) begin
      step();
      chk("latency", {9'd0, o_int_taken}, {9'd0, k == 2 + SL});
    end
    i_instr_done = 1'b0; i_intr = 1'b0;
    step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/int_shadow_ctrl.md
INT_SHADOW_CTRL -- requirements
Module: int_shadow_ctrl

Interface
REQ-001 The block SHALL have CLK, input, 1 bit: system clock; all state updates on the rising edge.
REQ-002 The block SHALL have RST_N, input, 1 bit: reset, asynchronous, active-low.
REQ-003 The block SHALL have INTR, input, 1 bit: external interrupt request level; an interrupt is requested on each 0->1 edge.
REQ-004 The block SHALL have C_FLAG and Z_FLAG, input, 1 bit each: current outputs of the FLAGS stage.
REQ-005 The block SHALL have I_SET and I_CLR, input, 1 bit each: SEI and CLI strobes from the control unit.
REQ-006 The block SHALL have INSTR_DONE, input, 1 bit: high in the last execute cycle of an instruction.
REQ-007 The block SHALL have RETIE, input, 1 bit: RETIE-execute strobe from the control unit.
REQ-008 The block SHALL have INT_TAKEN, output, 1 bit: one-cycle pulse telling the control unit to enter its interrupt cycle.
REQ-009 The block SHALL have SHAD_C and SHAD_Z, output, 1 bit each: saved flags.
REQ-010 The block SHALL have FLG_LD_SEL, output, 1 bit: 1 selects SHAD_C/SHAD_Z as the FLAGS load source.
REQ-011 The block SHALL have FLG_RESTORE, output, 1 bit: one-cycle load strobe to FLAGS (drives FLG_C_LD and FLG_Z_LD).
REQ-012 The block SHALL have I_FLAG, output, 1 bit: interrupt enable.
REQ-013 The block SHALL have INT_VECTOR, output, 10 bits: constant 10'h3FF.

Function
REQ-014 The FSM SHALL have states IDLE, TAKE, IN_ISR and RESTORE.
- IDLE->TAKE when PEND & I_FLAG & INSTR_DONE.
- TAKE->IN_ISR unconditionally.
- IN_ISR->RESTORE on RETIE.
- RESTORE->IDLE unconditionally.
REQ-015 A detected INTR rising edge SHALL set internal PEND in the next cycle; PEND SHALL hold until the edge entering TAKE clears it.
REQ-016 In TAKE the block SHALL assert INT_TAKEN for exactly one cycle, capture SHAD_C<=C_FLAG and SHAD_Z<=Z_FLAG at exit, and clear I_FLAG.
REQ-017 In RESTORE the block SHALL assert FLG_LD_SEL and FLG_RESTORE for exactly one cycle and set I_FLAG at exit; both are 0 in all other states.
REQ-018 I_SET/I_CLR SHALL act only in IDLE; if both are high, clear wins (matches FLAGS precedence CLR>LD>SET).
REQ-019 RETIE in IDLE or TAKE SHALL be ignored.
REQ-020 An INTR edge during TAKE, IN_ISR or RESTORE SHALL set PEND and be serviced after return; a second edge while PEND=1 SHALL be merged (no counting).
REQ-021 The block SHALL NOT support nested interrupts.
REQ-022 INSTR_DONE with PEND=1 and I_FLAG=0 SHALL keep the FSM in IDLE with PEND held.
REQ-023 Interrupt latency SHALL be: INT_TAKEN asserted in the cycle after the qualifying INSTR_DONE.

Reset
REQ-024 RST_N low SHALL immediately force state IDLE, PEND=0, I_FLAG=0, SHAD_C=0, SHAD_Z=0, INT_TAKEN=0, FLG_LD_SEL=0, FLG_RESTORE=0, and clear the edge-detect and synchronizer flops.
REQ-025 Reset asserted in any state, including mid-ISR, SHALL discard the pending interrupt and shadow contents.

Configuration
REQ-026 With INT_SYNC_EN defined, INTR SHALL pass a 2-flop synchronizer before edge detection, adding 2 cycles to PEND-set latency.
REQ-027 Without INT_SYNC_EN, INTR SHALL feed the edge detector directly, since the stimulus is assumed synchronous to CLK.

Structure
REQ-028 Package rat_int_pkg SHALL hold the state enum typedef and the INT_VECTOR localparam (10'h3FF).
REQ-029 Sub-module int_edge_sync SHALL contain the optional synchronizer and the rising-edge detector and output a 1-cycle pulse.

Verification
REQ-030 Reset then I_SET, INTR 0->1, INSTR_DONE pulse with C_FLAG=1, Z_FLAG=0: INT_TAKEN for 1 cycle after INSTR_DONE, SHAD_C=1, SHAD_Z=0, I_FLAG=0.
REQ-031 In IN_ISR, drive C_FLAG=0, Z_FLAG=1, then RETIE: FLG_LD_SEL=FLG_RESTORE=1 for 1 cycle with SHAD_C=1, SHAD_Z=0; I_FLAG=1 after; state IDLE.
REQ-032 I_FLAG=0 and INTR edge, 5 INSTR_DONE pulses: no INT_TAKEN; then I_SET plus INSTR_DONE: INT_TAKEN 1 cycle later.
REQ-033 I_SET and I_CLR both high in IDLE: I_FLAG=0; RETIE in IDLE: no FLG_RESTORE.
REQ-034 INTR edge during IN_ISR: after RESTORE and the next INSTR_DONE, second INT_TAKEN; two edges in IN_ISR yield a single INT_TAKEN.
REQ-035 RST_N low mid-ISR: all outputs 0 asynchronously and PEND lost; with INT_SYNC_EN, PEND sets 3 cycles after INTR rises (1 without).
